// File: rtl/bluetooth_tx.sv
// bluetooth_tx
//   8N1 UART transmitter (LSB first) feeding the RXD pin of an HC-05/06
//   Bluetooth module. Bytes pushed by game logic are queued in a small FIFO
//   and serialised back-to-back with no idle gap between frames.
//
// Parameters
//   BAUD_DIV  clocks per bit (default 100 MHz / 9600), legal range >= 2
//   FIFO_AW   FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   wr_en     in   push wr_data into the FIFO this cycle
//   wr_data   in   byte to send
//   full      out  FIFO holds 2**FIFO_AW entries; pushes are rejected
//   overflow  out  one-cycle pulse after a push attempted while full
//   count     out  FIFO occupancy, 0..2**FIFO_AW
//   busy      out  a frame is on the line
//   txd       out  registered serial output, idle high
module bluetooth_tx #(
   parameter int unsigned BAUD_DIV = 10417,
   parameter int unsigned FIFO_AW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   output logic               full,
   output logic               overflow,
   output logic [FIFO_AW:0]   count,
   output logic               busy,
   output logic               txd
);

   localparam int unsigned      DEPTH      = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_CNT  = DEPTH[FIFO_AW:0];
   localparam logic [FIFO_AW:0] CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0] CNT_ZERO   = {(FIFO_AW + 1){1'b0}};
   localparam logic [13:0]      BAUD_LAST  = 14'(BAUD_DIV - 1);
   localparam logic [2:0]       BIT_LAST   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // FIFO storage and bookkeeping
   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [FIFO_AW:0]   count_r;
   logic [FIFO_AW:0]   count_nxt_s;
   logic               full_r;
   logic               overflow_r;
   logic               push_s;
   logic               pop_s;

   // Serialiser state
   tx_state_t          state_r;
   tx_state_t          state_nxt_s;
   logic [13:0]        baud_r;
   logic [13:0]        baud_nxt_s;
   logic [2:0]         bit_idx_r;
   logic [2:0]         bit_idx_nxt_s;
   logic [7:0]         shreg_r;
   logic [7:0]         shreg_nxt_s;
   logic               txd_r;
   logic               txd_nxt_s;
   logic               busy_r;

   // full is judged on the pre-edge occupancy, so a pop on the same edge
   // never makes room for a push that arrives while full.
   assign push_s = wr_en & ~full_r;

   // Occupancy update: push and pop on the same edge leave count unchanged.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (!push_s && pop_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO data array; contents need no reset because pointers/count gate reads.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO pointers, occupancy, full flag and overflow pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {FIFO_AW{1'b0}};
         rd_ptr_r   <= {FIFO_AW{1'b0}};
         count_r    <= CNT_ZERO;
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1};
         end
         count_r    <= count_nxt_s;
         full_r     <= (count_nxt_s == DEPTH_CNT);
         overflow_r <= wr_en & full_r;
      end
   end

   // Next-state, counters and next txd value. txd is registered, so the
   // value computed here is the level for the state being entered.
   always_comb begin
      state_nxt_s   = state_r;
      baud_nxt_s    = baud_r + 14'd1;
      bit_idx_nxt_s = bit_idx_r;
      shreg_nxt_s   = shreg_r;
      txd_nxt_s     = 1'b1;
      pop_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            baud_nxt_s    = 14'd0;
            bit_idx_nxt_s = 3'd0;
            if (count_r != CNT_ZERO) begin
               pop_s       = 1'b1;
               shreg_nxt_s = mem_r[rd_ptr_r];
               state_nxt_s = ST_START;
               txd_nxt_s   = 1'b0;
            end else begin
               txd_nxt_s   = 1'b1;
            end
         end
         ST_START: begin
            txd_nxt_s = 1'b0;
            if (baud_r == BAUD_LAST) begin
               state_nxt_s   = ST_DATA;
               baud_nxt_s    = 14'd0;
               bit_idx_nxt_s = 3'd0;
               txd_nxt_s     = shreg_r[0];
            end else begin
               state_nxt_s   = ST_START;
            end
         end
         ST_DATA: begin
            txd_nxt_s = shreg_r[0];
            if (baud_r == BAUD_LAST) begin
               baud_nxt_s = 14'd0;
               if (bit_idx_r == BIT_LAST) begin
                  state_nxt_s = ST_STOP;
                  txd_nxt_s   = 1'b1;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
                  shreg_nxt_s   = {1'b0, shreg_r[7:1]};
                  txd_nxt_s     = shreg_r[1];
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STOP: begin
            txd_nxt_s = 1'b1;
            if (baud_r == BAUD_LAST) begin
               baud_nxt_s = 14'd0;
               // Chain straight into the next start bit when more data waits.
               if (count_r != CNT_ZERO) begin
                  pop_s       = 1'b1;
                  shreg_nxt_s = mem_r[rd_ptr_r];
                  state_nxt_s = ST_START;
                  txd_nxt_s   = 1'b0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            baud_nxt_s    = 14'd0;
            bit_idx_nxt_s = 3'd0;
            txd_nxt_s     = 1'b1;
         end
      endcase
   end

   // Serialiser state register and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         baud_r    <= 14'd0;
         bit_idx_r <= 3'd0;
         shreg_r   <= 8'd0;
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         baud_r    <= baud_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         shreg_r   <= shreg_nxt_s;
         txd_r     <= txd_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
      end
   end

   assign full     = full_r;
   assign overflow = overflow_r;
   assign count    = count_r;
   assign busy     = busy_r;
   assign txd      = txd_r;

endmodule

// File: tb/tb_bluetooth_tx.sv
// tb_bluetooth_tx
//   Drives bluetooth_tx (BAUD_DIV=4, FIFO_AW=2) with directed and random
//   pushes/resets and compares every output each cycle against a queue-based
//   frame-timing model of the transmitter.
module tb_bluetooth_tx;

   localparam int unsigned B     = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          overflow;
   logic [AW:0]   count;
   logic          busy;
   logic          txd;

   int checks;
   int errors;

   // Reference model state: queued bytes, current frame byte and time in frame.
   logic [7:0] mq[$];
   logic [7:0] m_byte;
   int         m_t;
   logic       m_act;
   logic       m_ovf;

   bluetooth_tx #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .overflow (overflow),
      .count    (count),
      .busy     (busy),
      .txd      (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line level of a frame t clocks after its start: start, 8 data bits LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int t);
      int k;
      k = t / B;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic logic exp_txd();
      return m_act ? frame_bit(m_byte, m_t) : 1'b1;
   endfunction

   // Advance the model by one clock edge using the pre-edge FIFO occupancy.
   task automatic model_step(input logic r, input logic we, input logic [7:0] d);
      int  size_pre;
      logic full_pre;
      if (r) begin
         mq.delete();
         m_act = 1'b0;
         m_t   = 0;
         m_ovf = 1'b0;
      end else begin
         size_pre = mq.size();
         full_pre = (size_pre == DEPTH);
         m_ovf    = we && full_pre;
         if (m_act) begin
            m_t++;
            if (m_t == 10 * B) begin
               if (size_pre != 0) begin
                  m_byte = mq.pop_front();
                  m_t    = 0;
               end else begin
                  m_act = 1'b0;
                  m_t   = 0;
               end
            end
         end else if (size_pre != 0) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_t    = 0;
         end
         if (we && !full_pre) mq.push_back(d);
      end
   endtask

   task automatic step(input logic r, input logic we, input logic [7:0] d);
      @(negedge clk);
      rst     = r;
      wr_en   = we;
      wr_data = d;
      @(posedge clk);
      model_step(r, we, d);
      #1;
      check_val("txd", {31'd0, txd}, {31'd0, exp_txd()});
      check_val("busy", {31'd0, busy}, {31'd0, m_act});
      check_val("count", 32'(count), 32'(mq.size()));
      check_val("full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
      check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
   endtask

   initial begin
      logic [9:0] a5_seq;
      logic [7:0] rb;
      int         wait_cnt;
      checks  = 0;
      errors  = 0;
      m_act   = 1'b0;
      m_t     = 0;
      m_ovf   = 1'b0;
      m_byte  = 8'd0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'd0;

      // 1: reset then quiet line
      step(1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 8'h33);
      idle(20);

      // 2: single 0xA5 frame, mid-bit samples against the literal sequence
      a5_seq = 10'b1101001010;
      step(1'b0, 1'b1, 8'hA5);
      for (int j = 1; j <= 10 * B; j++) begin
         step(1'b0, 1'b0, 8'h00);
         if (((j - 1) % B) == (B / 2)) begin
            check_val("a5_midbit", {31'd0, txd}, {31'd0, a5_seq[(j - 1) / B]});
         end
      end
      step(1'b0, 1'b0, 8'h00);
      check_val("a5_end_busy", {31'd0, busy}, 32'd0);
      check_val("a5_end_txd", {31'd0, txd}, 32'd1);
      idle(5);

      // 3: three bytes back-to-back
      step(1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h02);
      step(1'b0, 1'b1, 8'h03);
      idle(3 * 10 * B + 5);

      // 4/5: six pushes while idle, then hold pushes so one lands on a STOP->START pop
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
      for (int i = 0; i < 10 * B + 4; i++) step(1'b0, 1'b1, 8'hEE);
      idle(6 * 10 * B);

      // 6: reset during data bit 3 of 0x5A with two bytes queued
      step(1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b1, 8'hC3);
      step(1'b0, 1'b1, 8'h3C);
      wait_cnt = 0;
      while (!(m_act && m_byte == 8'h5A && m_t == 4 * B + 1) && wait_cnt < 100) begin
         step(1'b0, 1'b0, 8'h00);
         wait_cnt++;
      end
      check_val("reach_bit3", 32'(wait_cnt < 100), 32'd1);
      step(1'b1, 1'b0, 8'h00);
      check_val("rst_txd", {31'd0, txd}, 32'd1);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_count", 32'(count), 32'd0);
      idle(60);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rb = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 599) == 0) begin
            step(1'b1, 1'($urandom_range(0, 1)), rb);
         end else if ($urandom_range(0, 99) < 8) begin
            step(1'b0, 1'b1, rb);
         end else begin
            step(1'b0, 1'b0, rb);
         end
      end
      idle(6 * 10 * B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
